seq_detect_prog: RTL and testbench
==================================

// Module: seq_detect_prog
// PURPOSE
//  Programmable serial bit-sequence detector for gapped input. It accepts one bit per
//  cycle when data_valid=1 and ignores cycles with data_valid=0.
//  Pattern, length, don't-care mask and overlap mode are runtime-configurable.
//  An optional gap timeout discards stale history. It replaces the fixed-pattern
//  detectors used in the serial front-ends.
// PARAMETERS
//  PAT_W    8          max pattern length in bits (>=2)
//  RST_PAT  8'b0000_0110  pattern after reset; only the low RST_LEN bits are used
//  RST_LEN  4          pattern length after reset (1..PAT_W)
//  GAP_MAX  0          idle cycles without data_valid before history is cleared; 0 = timeout off
//  CNT_W    16         match counter width (optional feature)
// PORTS
//  clk        in   1        clock
//  rst_n      in   1        asynchronous active-low reset
//  data       in   1        serial bit, sampled only when data_valid=1
//  data_valid in   1        sample qualifier
//  cfg_load   in   1        1-cycle pulse: latch cfg_pat/cfg_mask/cfg_len/cfg_ovlp
//  cfg_pat    in   PAT_W    pattern; bit[len-1] = oldest, bit[0] = newest sample
//  cfg_mask   in   PAT_W    1 = compare this bit, 0 = don't care
//  cfg_len    in   $clog2(PAT_W+1)  pattern length
//  cfg_ovlp   in   1        1 = overlapping matches allowed, 0 = history restarts after a match
//  cnt_clr    in   1        synchronous clear of match_cnt
//  match      out  1        1-cycle pulse, one cycle after the sample that completes the pattern
//  match_cnt  out  CNT_W    saturating match count
// BEHAVIOUR
//  - Reset: hist=0, fill=0, gap=0, match=0, match_cnt=0.
//    Config registers after reset: pat=RST_PAT, mask=all 1s, len=RST_LEN, ovlp=1.
//  - On data_valid: hist <= {hist[PAT_W-2:0], data}.
//    fill <= min(fill+1, PAT_W), where fill is the count of valid samples since the last clear.
//  - Match condition (combinational, evaluated on a data_valid cycle):
//    win = {hist[len-2:0], data}; hit = (((win ^ pat) & mask)[len-1:0] == 0) && (fill+1 >= len).
//  - match <= hit, registered, so latency is exactly 1 clk after the completing sample.
//    match=0 on every other cycle, including data_valid=0 cycles.
//  - The fill guard stops reset-zero history from matching all-0 patterns.
//  - cfg_ovlp=0 and hit: fill <= 0 in the same edge; hist still shifts.
//  - Length rules: len=0 never matches; len>PAT_W is clamped to PAT_W at load.
//    len=1 matches on every qualifying sample.
//  - cfg_load: latches config and clears fill and gap. A data_valid in the same cycle
//    is dropped, with no shift and no match. cfg_load has priority over data_valid.
//  - Gap timeout (GAP_MAX>0): gap increments on each cycle with data_valid=0,
//    saturating at GAP_MAX. When gap reaches GAP_MAX, fill <= 0.
//    Any data_valid cycle sets gap <= 0. GAP_MAX=0 means no gap logic.
//  - Reset mid-stream: all state is cleared immediately. Partial matches are lost
//    and a pending match pulse is suppressed.
// CONFIGURATION
//  - SEQ_DET_CNT_EN defined: match_cnt increments on each hit and saturates at 2^CNT_W-1.
//    If cnt_clr=1 and hit occur in the same cycle, the result is match_cnt=0 (clear wins).
//  - SEQ_DET_CNT_EN undefined: no counter logic, match_cnt tied to 0, cnt_clr ignored.
// TESTING
//  1. Reset defaults; valid bits 0,1,1,0 with 1-3 idle cycles between them
//     -> match=1 for exactly 1 cycle, 1 clk after the 4th sample.
//  2. Load pat=3'b101, len=3, ovlp=1; stream 1,0,1,0,1 -> match after samples 3 and 5.
//     Same stream with ovlp=0 -> match after sample 3 only.
//  3. Load pat=3'b000, len=3 after reset; feed 0,0 -> no match; third 0 -> match.
//  4. Load pat=4'b1001, mask=4'b1011; stream 1,1,0,1 -> match; stream 1,0,0,1 -> match;
//     stream 1,1,1,1 -> no match.
//  5. GAP_MAX=3, default pattern; feed 0,1,1, idle 3 cycles, then 0 -> no match.
//     Same with idle 2 cycles -> match.
//  6. cfg_load between samples 3 and 4 of 0110 -> no match. rst_n low mid-pattern -> no match.
//     With SEQ_DET_CNT_EN and CNT_W=2, 5 matches -> match_cnt=3; cnt_clr -> match_cnt=0.

Source files
------------

// File: rtl/seq_detect_prog.sv
// rtl/seq_detect_prog.sv - programmable serial sequence detector; match counter enabled by SEQ_DET_CNT_EN
module seq_detect_prog #(
  parameter int               PAT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = 8'b0000_0110,
  parameter int               RST_LEN = 4,
  parameter int               GAP_MAX = 0,
  parameter int               CNT_W   = 16,
  localparam int              LEN_W   = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data,
  input  logic             data_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_ovlp,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

  logic [PAT_W-1:0] pat;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] len;
  logic             ovlp;

  // Only PAT_W-1 past samples are ever needed: the newest bit of the window is the live input.
  logic [PAT_W-2:0] hist;
  logic [LEN_W-1:0] fill;

  logic [PAT_W-1:0] win;
  logic [PAT_W-1:0] len_mask;
  logic             sample;
  logic             fill_ok;
  logic             hit;
  logic             gap_expire;

  assign win    = {hist, data};
  assign sample = data_valid && !cfg_load;

  // Restrict the comparison to the low len bits of the window.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len));
    end
  end

  assign fill_ok = (({1'b0, fill} + 1'b1) >= {1'b0, len});
  assign hit     = sample && (len != '0) && fill_ok &&
                   (((win ^ pat) & mask & len_mask) == '0);

  // Runtime configuration, clamping over-long lengths to the physical window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat  <= RST_PAT;
      mask <= '1;
      len  <= LEN_W'(RST_LEN);
      ovlp <= 1'b1;
    end else if (cfg_load) begin
      pat  <= cfg_pat;
      mask <= cfg_mask;
      len  <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      ovlp <= cfg_ovlp;
    end
  end

  // Sample history and fill level; fill restarts on load, non-overlapped hit or gap timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      fill <= '0;
    end else if (cfg_load) begin
      fill <= '0;
    end else if (data_valid) begin
      hist <= win[PAT_W-2:0];
      if (hit && !ovlp) begin
        fill <= '0;
      end else if (fill != LEN_MAX) begin
        fill <= fill + 1'b1;
      end
    end else if (gap_expire) begin
      fill <= '0;
    end
  end

  // Registered match pulse, one clock after the completing sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match <= 1'b0;
    end else begin
      match <= hit;
    end
  end

  generate
    if (GAP_MAX > 0) begin : g_gap
      localparam int GAP_W = $clog2(GAP_MAX + 1);
      logic [GAP_W-1:0] gap;

      // Idle-cycle counter, saturating at GAP_MAX.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          gap <= '0;
        end else if (cfg_load || data_valid) begin
          gap <= '0;
        end else if (gap != GAP_W'(GAP_MAX)) begin
          gap <= gap + 1'b1;
        end
      end

      // History goes stale on the idle cycle that brings gap to GAP_MAX.
      assign gap_expire = !cfg_load && !data_valid && (gap >= GAP_W'(GAP_MAX - 1));
    end else begin : g_no_gap
      assign gap_expire = 1'b0;
    end
  endgenerate

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating hit counter; a clear in the same cycle as a hit wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign match_cnt = cnt_q;
`else
  logic cnt_clr_unused;

  assign cnt_clr_unused = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb/tb_seq_detect_prog.sv - scoreboard bench for seq_detect_prog (GAP_MAX=0 and GAP_MAX=3 instances)
module tb_seq_detect_prog;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 2;
`ifdef SEQ_DET_CNT_EN
  localparam int CNT_ON = 1;
`else
  localparam int CNT_ON = 0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             data = 1'b0;
  logic             data_valid = 1'b0;
  logic             cfg_load = 1'b0;
  logic [PAT_W-1:0] cfg_pat = '0;
  logic [PAT_W-1:0] cfg_mask = '1;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_ovlp = 1'b1;
  logic             cnt_clr = 1'b0;
  logic             m0, m1;
  logic [CNT_W-1:0] c0, c1;

  int checks = 0;
  int errors = 0;
  int cur_id = 0;
  int last_id = -1;
  logic fresh = 1'b0;
  int q0[$];
  int q1[$];

  seq_detect_prog #(.PAT_W(PAT_W), .GAP_MAX(0), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .rst_n(rst_n), .data(data), .data_valid(data_valid),
    .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_mask(cfg_mask), .cfg_len(cfg_len),
    .cfg_ovlp(cfg_ovlp), .cnt_clr(cnt_clr), .match(m0), .match_cnt(c0)
  );

  seq_detect_prog #(.PAT_W(PAT_W), .GAP_MAX(3), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .rst_n(rst_n), .data(data), .data_valid(data_valid),
    .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_mask(cfg_mask), .cfg_len(cfg_len),
    .cfg_ovlp(cfg_ovlp), .cnt_clr(cnt_clr), .match(m1), .match_cnt(c1)
  );

  always #5 clk = ~clk;

  // Remember which sample the DUT accepted at the latest edge.
  always @(posedge clk) begin
    fresh <= data_valid && !cfg_load && rst_n;
    if (data_valid && !cfg_load && rst_n) last_id <= cur_id;
  end

  // Monitor: every match pulse must correspond to the next expected sample id.
  always @(negedge clk) begin
    if (m0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL spurious_match dut0 sample=%0d got match=1 required 0", last_id);
      end else begin
        int e;
        e = q0.pop_front();
        if (e != last_id || !fresh) begin
          errors++;
          $display("FAIL match_sample dut0 got sample=%0d fresh=%0b required sample=%0d fresh=1", last_id, fresh, e);
        end
      end
    end
    if (m1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL spurious_match dut1 sample=%0d got match=1 required 0", last_id);
      end else begin
        int e;
        e = q1.pop_front();
        if (e != last_id || !fresh) begin
          errors++;
          $display("FAIL match_sample dut1 got sample=%0d fresh=%0b required sample=%0d fresh=1", last_id, fresh, e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic b, input logic e0, input logic e1);
    data = b;
    data_valid = 1'b1;
    cur_id++;
    if (e0) q0.push_back(cur_id);
    if (e1) q1.push_back(cur_id);
    @(posedge clk); #1;
    data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic load(input logic [PAT_W-1:0] p, input logic [PAT_W-1:0] mk,
                      input logic [LEN_W-1:0] l, input logic ov);
    cfg_pat = p; cfg_mask = mk; cfg_len = l; cfg_ovlp = ov;
    cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic end_test(input string name);
    idle(3);
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL %s missing_match dut0 got %0d pending required 0", name, q0.size());
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL %s missing_match dut1 got %0d pending required 0", name, q1.size());
    end
    q0.delete();
    q1.delete();
  endtask

  initial begin
    @(posedge clk); #1;
    #2;
    check_val("reset_match0", int'(m0), 0);
    check_val("reset_match1", int'(m1), 0);
    check_val("reset_cnt0", int'(c0), 0);
    check_val("reset_cnt1", int'(c1), 0);
    rst_n = 1'b1;
    idle(1);

    // 1: default pattern 0110 with idle gaps between samples
    send(0, 0, 0); idle(1);
    send(1, 0, 0); idle(2);
    send(1, 0, 0); idle(2);
    send(0, 1, 1);
    end_test("default_0110");

    // 2: 101 overlapping, then non-overlapping
    load(8'b101, 8'hFF, 4'd3, 1'b1);
    send(1, 0, 0); send(0, 0, 0); send(1, 1, 1); send(0, 0, 0); send(1, 1, 1);
    end_test("ovlp_101");
    load(8'b101, 8'hFF, 4'd3, 1'b0);
    send(1, 0, 0); send(0, 0, 0); send(1, 1, 1); send(0, 0, 0); send(1, 0, 0);
    end_test("no_ovlp_101");

    // 3: all-zero pattern must wait for a full window after reset
    do_reset();
    load(8'b000, 8'hFF, 4'd3, 1'b1);
    send(0, 0, 0); send(0, 0, 0);
    idle(2);
    send(0, 1, 1);
    end_test("zero_pattern");

    // 4: don't-care mask
    load(8'b1001, 8'b1011, 4'd4, 1'b1);
    send(1, 0, 0); send(1, 0, 0); send(0, 0, 0); send(1, 1, 1);
    end_test("mask_1101");
    load(8'b1001, 8'b1011, 4'd4, 1'b1);
    send(1, 0, 0); send(0, 0, 0); send(0, 0, 0); send(1, 1, 1);
    end_test("mask_1001");
    load(8'b1001, 8'b1011, 4'd4, 1'b1);
    send(1, 0, 0); send(1, 0, 0); send(1, 0, 0); send(1, 0, 0);
    end_test("mask_1111");

    // 5: gap timeout only on the GAP_MAX=3 instance
    load(8'b0110, 8'hFF, 4'd4, 1'b1);
    send(0, 0, 0); send(1, 0, 0); send(1, 0, 0); idle(3); send(0, 1, 0);
    end_test("gap_3_idle");
    load(8'b0110, 8'hFF, 4'd4, 1'b1);
    send(0, 0, 0); send(1, 0, 0); send(1, 0, 0); idle(2); send(0, 1, 1);
    end_test("gap_2_idle");

    // 6: load mid-pattern, reset mid-pattern, reset on a pending pulse
    send(0, 0, 0); send(1, 0, 0); send(1, 0, 0);
    load(8'b0110, 8'hFF, 4'd4, 1'b1);
    send(0, 0, 0);
    end_test("load_mid_pattern");
    send(0, 0, 0); send(1, 0, 0); send(1, 0, 0);
    do_reset();
    send(0, 0, 0);
    end_test("reset_mid_pattern");
    send(0, 0, 0); send(1, 0, 0); send(1, 0, 0); send(0, 0, 0);
    rst_n = 1'b0;
    #2;
    check_val("reset_kills_pulse0", int'(m0), 0);
    check_val("reset_kills_pulse1", int'(m1), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    end_test("reset_pending");

    // Length boundaries: len=0 never, len>PAT_W clamps to PAT_W
    load(8'h00, 8'hFF, 4'd0, 1'b1);
    send(0, 0, 0); send(0, 0, 0); send(1, 0, 0);
    end_test("len_zero");
    load(8'hA5, 8'hFF, 4'd15, 1'b1);
    send(1, 0, 0); send(0, 0, 0); send(1, 0, 0); send(0, 0, 0);
    send(0, 0, 0); send(1, 0, 0); send(0, 0, 0); send(1, 1, 1);
    end_test("len_clamp");

    // len=1 and the saturating counter
    do_reset();
    load(8'b1, 8'hFF, 4'd1, 1'b1);
    for (int i = 0; i < 5; i++) send(1, 1, 1);
    send(0, 0, 0);
    end_test("len_one");
    check_val("cnt_sat0", int'(c0), CNT_ON * 3);
    check_val("cnt_sat1", int'(c1), CNT_ON * 3);
    cnt_clr = 1'b1;
    idle(1);
    cnt_clr = 1'b0;
    check_val("cnt_clr0", int'(c0), 0);
    check_val("cnt_clr1", int'(c1), 0);
    cnt_clr = 1'b1;
    send(1, 1, 1);
    cnt_clr = 1'b0;
    check_val("cnt_clr_wins0", int'(c0), 0);
    check_val("cnt_clr_wins1", int'(c1), 0);
    send(1, 1, 1);
    check_val("cnt_one0", int'(c0), CNT_ON);
    check_val("cnt_one1", int'(c1), CNT_ON);
    end_test("cnt_after_clr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
